fetch_sequencer: RTL and testbench

- Sequences the instruction fetch unit: owns the PC, issues word reads to instruction memory, and classifies each returned word.
- Control words (bits[31:26]=6'b111111) drive the communication and CU-enable side channel.
- All other words go to the control unit over a valid/ready handshake.
- Sits between instruction memory and the control unit. Also handles branch redirects and the START/STOP/END control protocol.

---
 rtl/fetch_pkg.sv | 23 ++
 rtl/ins_classifier.sv | 21 ++
 rtl/fetch_sequencer.sv | 163 ++++++++++++++++
 tb/tb_fetch_sequencer.sv | 482 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch path and the control unit.
package fetch_pkg;

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    WAIT_MEM,
    ISSUE,
    COMM,
    PAUSE,
    HALT
  } fetch_state_t;

  localparam logic [5:0] CTRL_OPCODE = 6'b111111;

  localparam logic [1:0] SUB_START = 2'b10;
  localparam logic [1:0] SUB_STOP  = 2'b11;
  localparam logic [1:0] SUB_END   = 2'b00;
  localparam logic [1:0] SUB_NOP   = 2'b01;

  localparam int SIG_WIDTH = 19;

endpackage

// File: rtl/ins_classifier.sv
// Splits an instruction word into control flag, control subcode and side-channel payload.
module ins_classifier
  import fetch_pkg::*;
#(
  parameter int bus_width = 32
) (
  input  logic [bus_width-1:0] word,
  output logic                 is_ctrl,
  output logic [1:0]           subcode,
  output logic [SIG_WIDTH-1:0] payload
);

  // The low bits carry nothing for the fetch path; folding them here keeps them visibly consumed.
  logic unused_low_bits;

  assign is_ctrl         = (word[bus_width-1 -: 6] == CTRL_OPCODE);
  assign subcode         = word[bus_width-7 -: 2];
  assign payload         = word[bus_width-7 -: SIG_WIDTH];
  assign unused_low_bits = ^word[bus_width-SIG_WIDTH-7:0];

endmodule

// File: rtl/fetch_sequencer.sv
// Owns the PC, reads instruction memory, and routes each word to the CU or the comm side channel.
module fetch_sequencer
  import fetch_pkg::*;
#(
  parameter int          bus_width  = 32,
  parameter int          addr_width = 16,
  parameter int unsigned start_addr = 0
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  run_in,
  output logic                  mem_req_out,
  output logic [addr_width-1:0] mem_addr_out,
  input  logic                  mem_ready_in,
  input  logic [bus_width-1:0]  mem_data_in,
  output logic [bus_width-1:0]  ins_out,
  output logic                  ins_valid_out,
  input  logic                  ins_ready_in,
  input  logic                  branch_valid_in,
  input  logic [addr_width-1:0] branch_target_in,
  output logic [SIG_WIDTH-1:0]  signal_out,
  output logic                  comm_valid_out,
  input  logic                  comm_ack_in,
  output logic                  cu_enable_out,
  output logic                  halted_out
);

  localparam logic [addr_width-1:0] START_PC = addr_width'(start_addr);

  fetch_state_t          state;
  logic [addr_width-1:0] pc;
  logic [addr_width-1:0] pc_inc;
  logic                  discard;
  logic                  is_ctrl;
  logic [1:0]            subcode;
  logic [SIG_WIDTH-1:0]  payload;

  ins_classifier #(.bus_width(bus_width)) u_classifier (
    .word    (mem_data_in),
    .is_ctrl (is_ctrl),
    .subcode (subcode),
    .payload (payload)
  );

  assign mem_addr_out = pc;
  assign pc_inc       = pc + 1'b1;

  always_ff @(posedge clock) begin
    if (reset) begin
      state          <= IDLE;
      pc             <= START_PC;
      discard        <= 1'b0;
      mem_req_out    <= 1'b0;
      ins_out        <= '0;
      ins_valid_out  <= 1'b0;
      signal_out     <= '0;
      comm_valid_out <= 1'b0;
      cu_enable_out  <= 1'b0;
      halted_out     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (run_in) begin
            state       <= FETCH;
            mem_req_out <= 1'b1;
          end
        end

        // A redirect here arrives after the request left, so the old word must be dropped.
        FETCH: begin
          mem_req_out <= 1'b0;
          state       <= WAIT_MEM;
          if (branch_valid_in) begin
            pc      <= branch_target_in;
            discard <= 1'b1;
          end
        end

        WAIT_MEM: begin
          if (branch_valid_in)
            pc <= branch_target_in;
          if (!mem_ready_in) begin
            if (branch_valid_in)
              discard <= 1'b1;
          end else if (discard || branch_valid_in) begin
            discard     <= 1'b0;
            state       <= FETCH;
            mem_req_out <= 1'b1;
          end else if (!is_ctrl) begin
            pc            <= pc_inc;
            ins_out       <= mem_data_in;
            ins_valid_out <= 1'b1;
            cu_enable_out <= 1'b1;
            state         <= ISSUE;
          end else begin
            case (subcode)
              SUB_START: begin
                pc             <= pc_inc;
                signal_out     <= payload;
                comm_valid_out <= 1'b1;
                state          <= COMM;
              end
              SUB_STOP: begin
                pc             <= pc_inc;
                signal_out     <= payload;
                comm_valid_out <= 1'b1;
                cu_enable_out  <= 1'b0;
                state          <= PAUSE;
              end
              SUB_END: begin
                signal_out     <= payload;
                comm_valid_out <= 1'b1;
                cu_enable_out  <= 1'b0;
                halted_out     <= 1'b1;
                state          <= HALT;
              end
              SUB_NOP: begin
                pc          <= pc_inc;
                state       <= FETCH;
                mem_req_out <= 1'b1;
              end
            endcase
          end
        end

        ISSUE: begin
          if (branch_valid_in)
            pc <= branch_target_in;
          if (ins_ready_in) begin
            ins_valid_out <= 1'b0;
            state         <= FETCH;
            mem_req_out   <= 1'b1;
          end
        end

        COMM: begin
          if (comm_ack_in) begin
            comm_valid_out <= 1'b0;
            state          <= FETCH;
            mem_req_out    <= 1'b1;
          end
        end

        // STOP notifies the comm block with a single-cycle pulse; no ack is awaited.
        PAUSE: begin
          comm_valid_out <= 1'b0;
          if (run_in) begin
            state       <= FETCH;
            mem_req_out <= 1'b1;
          end
        end

        HALT: begin
          if (comm_ack_in)
            comm_valid_out <= 1'b0;
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_sequencer.sv
// Self-checking bench for fetch_sequencer: a latency-modelled memory plus scoreboard queues of expected words.
module tb_fetch_sequencer;
  import fetch_pkg::*;

  logic                 clock = 1'b0;
  logic                 reset;
  logic                 run_in;
  logic                 mem_req_out;
  logic [15:0]          mem_addr_out;
  logic                 mem_ready_in;
  logic [31:0]          mem_data_in;
  logic [31:0]          ins_out;
  logic                 ins_valid_out;
  logic                 ins_ready_in;
  logic                 branch_valid_in;
  logic [15:0]          branch_target_in;
  logic [SIG_WIDTH-1:0] signal_out;
  logic                 comm_valid_out;
  logic                 comm_ack_in;
  logic                 cu_enable_out;
  logic                 halted_out;

  int tests_run    = 0;
  int tests_failed = 0;

  logic [31:0]          mem [logic [15:0]];
  int                   mem_lat   = 2;
  int                   req_count = 0;
  logic [15:0]          addr_q[$];
  logic [31:0]          exp_ins_q[$];
  logic [SIG_WIDTH-1:0] exp_sig_q[$];

  fetch_sequencer dut (
    .clock            (clock),
    .reset            (reset),
    .run_in           (run_in),
    .mem_req_out      (mem_req_out),
    .mem_addr_out     (mem_addr_out),
    .mem_ready_in     (mem_ready_in),
    .mem_data_in      (mem_data_in),
    .ins_out          (ins_out),
    .ins_valid_out    (ins_valid_out),
    .ins_ready_in     (ins_ready_in),
    .branch_valid_in  (branch_valid_in),
    .branch_target_in (branch_target_in),
    .signal_out       (signal_out),
    .comm_valid_out   (comm_valid_out),
    .comm_ack_in      (comm_ack_in),
    .cu_enable_out    (cu_enable_out),
    .halted_out       (halted_out)
  );

  always #5 clock = ~clock;

  // Payload of a control word: bits [25:7] of a 32-bit word.
  function automatic logic [SIG_WIDTH-1:0] payload_of(input logic [31:0] w);
    logic [SIG_WIDTH-1:0] p;
    for (int i = 0; i < SIG_WIDTH; i++)
      p[i] = w[7 + i];
    return p;
  endfunction

  // Memory model: answers each request mem_lat cycles later with a one-cycle ready pulse.
  initial begin
    mem_ready_in = 1'b0;
    mem_data_in  = '0;
    forever begin
      @(negedge clock);
      mem_ready_in = 1'b0;
      if (mem_req_out === 1'b1) begin
        logic [15:0] a;
        a = mem_addr_out;
        addr_q.push_back(a);
        req_count++;
        repeat (mem_lat - 1) @(negedge clock);
        mem_data_in  = mem.exists(a) ? mem[a] : 32'h0;
        mem_ready_in = 1'b1;
      end
    end
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic reset_dut();
    reset            = 1'b1;
    run_in           = 1'b0;
    ins_ready_in     = 1'b0;
    branch_valid_in  = 1'b0;
    branch_target_in = '0;
    comm_ack_in      = 1'b0;
    mem_lat          = 2;
    repeat (8) @(negedge clock);
    mem.delete();
    addr_q.delete();
    exp_ins_q.delete();
    exp_sig_q.delete();
    req_count = 0;
    reset     = 1'b0;
  endtask

  task automatic pulse_run();
    run_in = 1'b1;
    @(negedge clock);
    run_in = 1'b0;
  endtask

  task automatic wait_ins(output bit seen);
    seen = 1'b0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clock);
      if (ins_valid_out === 1'b1) begin
        seen = 1'b1;
        break;
      end
    end
  endtask

  task automatic wait_comm(output bit seen);
    seen = 1'b0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clock);
      if (comm_valid_out === 1'b1) begin
        seen = 1'b1;
        break;
      end
    end
  endtask

  task automatic wait_reqs(input int n, output bit seen);
    seen = 1'b0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clock);
      if (addr_q.size() >= n) begin
        seen = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    reset            = 1'b1;
    run_in           = 1'b1;
    ins_ready_in     = 1'b0;
    branch_valid_in  = 1'b0;
    branch_target_in = '0;
    comm_ack_in      = 1'b0;
    repeat (3) @(negedge clock);
    tests_run++;
    if ({mem_req_out, ins_valid_out, comm_valid_out, cu_enable_out, halted_out} !== 5'b0) begin
      tests_failed++;
      $display("[TB] FAIL reset_flags: got %b want 00000",
               {mem_req_out, ins_valid_out, comm_valid_out, cu_enable_out, halted_out});
    end
    tests_run++;
    if (mem_addr_out !== 16'h0000) begin
      tests_failed++;
      $display("[TB] FAIL reset_pc: got %h want 0000", mem_addr_out);
    end
    tests_run++;
    if (ins_out !== 32'h0 || signal_out !== 19'h0) begin
      tests_failed++;
      $display("[TB] FAIL reset_data: got ins %h sig %h want 0 0", ins_out, signal_out);
    end
    run_in = 1'b0;
  endtask

  task automatic test_basic_issue();
    bit seen;
    reset_dut();
    mem[16'h0000] = 32'h0000_1234;
    mem[16'h0001] = 32'h0000_5678;
    exp_ins_q.push_back(32'h0000_1234);
    exp_ins_q.push_back(32'h0000_5678);
    ins_ready_in = 1'b1;
    pulse_run();
    wait_ins(seen);
    tests_run++;
    if (!seen || ins_out !== exp_ins_q[0] || cu_enable_out !== 1'b1) begin
      tests_failed++;
      $display("[TB] FAIL basic_issue: got seen %0d ins %h cu_en %b want 1 %h 1",
               seen, ins_out, cu_enable_out, exp_ins_q[0]);
    end
    void'(exp_ins_q.pop_front());
    @(negedge clock);
    tests_run++;
    if (ins_valid_out !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL basic_valid_pulse: got %b want 0", ins_valid_out);
    end
    wait_reqs(2, seen);
    tests_run++;
    if (!seen || addr_q[0] !== 16'h0000 || addr_q[1] !== 16'h0001) begin
      tests_failed++;
      $display("[TB] FAIL basic_addrs: got %0d reqs first %h second %h want 0000 0001",
               addr_q.size(), seen ? addr_q[0] : 16'hxxxx, seen ? addr_q[1] : 16'hxxxx);
    end
    wait_ins(seen);
    tests_run++;
    if (!seen || ins_out !== exp_ins_q[0]) begin
      tests_failed++;
      $display("[TB] FAIL basic_second: got seen %0d ins %h want %h", seen, ins_out, exp_ins_q[0]);
    end
    void'(exp_ins_q.pop_front());
  endtask

  task automatic test_start_comm();
    bit seen;
    int reqs_before;
    reset_dut();
    mem[16'h0000] = 32'hFE00_0080;
    mem[16'h0001] = 32'h0000_00AA;
    exp_sig_q.push_back(payload_of(32'hFE00_0080));
    exp_ins_q.push_back(32'h0000_00AA);
    ins_ready_in = 1'b1;
    pulse_run();
    wait_comm(seen);
    reqs_before = req_count;
    for (int i = 0; i < 3; i++) begin
      tests_run++;
      if (!seen || comm_valid_out !== 1'b1 || signal_out !== exp_sig_q[0] || req_count !== reqs_before) begin
        tests_failed++;
        $display("[TB] FAIL start_hold%0d: got valid %b sig %h reqs %0d want 1 %h %0d",
                 i, comm_valid_out, signal_out, req_count, exp_sig_q[0], reqs_before);
      end
      if (i < 2) @(negedge clock);
    end
    void'(exp_sig_q.pop_front());
    comm_ack_in = 1'b1;
    @(negedge clock);
    comm_ack_in = 1'b0;
    tests_run++;
    if (comm_valid_out !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL start_ack_drop: got %b want 0", comm_valid_out);
    end
    wait_reqs(2, seen);
    tests_run++;
    if (!seen || addr_q[1] !== 16'h0001) begin
      tests_failed++;
      $display("[TB] FAIL start_next_addr: got %h want 0001", seen ? addr_q[1] : 16'hxxxx);
    end
    wait_ins(seen);
    tests_run++;
    if (!seen || ins_out !== exp_ins_q[0]) begin
      tests_failed++;
      $display("[TB] FAIL start_following: got %h want %h", ins_out, exp_ins_q[0]);
    end
    void'(exp_ins_q.pop_front());
  endtask

  task automatic test_stop();
    bit seen;
    reset_dut();
    mem[16'h0000] = 32'h0000_0011;
    mem[16'h0001] = 32'hFF00_0000;
    mem[16'h0002] = 32'h0000_0022;
    exp_ins_q.push_back(32'h0000_0011);
    exp_sig_q.push_back(payload_of(32'hFF00_0000));
    exp_ins_q.push_back(32'h0000_0022);
    ins_ready_in = 1'b1;
    pulse_run();
    wait_ins(seen);
    tests_run++;
    if (!seen || ins_out !== exp_ins_q[0] || cu_enable_out !== 1'b1) begin
      tests_failed++;
      $display("[TB] FAIL stop_pre_word: got %h cu_en %b want %h 1", ins_out, cu_enable_out, exp_ins_q[0]);
    end
    void'(exp_ins_q.pop_front());
    wait_comm(seen);
    tests_run++;
    if (!seen || signal_out !== exp_sig_q[0] || cu_enable_out !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL stop_comm: got sig %h cu_en %b want %h 0", signal_out, cu_enable_out, exp_sig_q[0]);
    end
    void'(exp_sig_q.pop_front());
    @(negedge clock);
    tests_run++;
    if (comm_valid_out !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL stop_pulse: got %b want 0", comm_valid_out);
    end
    repeat (10) @(negedge clock);
    tests_run++;
    if (req_count !== 2 || mem_req_out !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL stop_paused: got %0d reqs want 2", req_count);
    end
    pulse_run();
    wait_reqs(3, seen);
    tests_run++;
    if (!seen || addr_q[2] !== 16'h0002) begin
      tests_failed++;
      $display("[TB] FAIL stop_resume_addr: got %h want 0002", seen ? addr_q[2] : 16'hxxxx);
    end
    wait_ins(seen);
    tests_run++;
    if (!seen || ins_out !== exp_ins_q[0] || cu_enable_out !== 1'b1) begin
      tests_failed++;
      $display("[TB] FAIL stop_resume_word: got %h cu_en %b want %h 1", ins_out, cu_enable_out, exp_ins_q[0]);
    end
    void'(exp_ins_q.pop_front());
  endtask

  task automatic test_end();
    bit seen;
    reset_dut();
    mem[16'h0000] = 32'hFC00_0000;
    mem[16'h0001] = 32'h0000_0099;
    exp_sig_q.push_back(payload_of(32'hFC00_0000));
    pulse_run();
    wait_comm(seen);
    tests_run++;
    if (!seen || halted_out !== 1'b1 || cu_enable_out !== 1'b0 || signal_out !== exp_sig_q[0]) begin
      tests_failed++;
      $display("[TB] FAIL end_halt: got halted %b cu_en %b sig %h want 1 0 %h",
               halted_out, cu_enable_out, signal_out, exp_sig_q[0]);
    end
    void'(exp_sig_q.pop_front());
    comm_ack_in = 1'b1;
    @(negedge clock);
    comm_ack_in = 1'b0;
    tests_run++;
    if (comm_valid_out !== 1'b0 || halted_out !== 1'b1) begin
      tests_failed++;
      $display("[TB] FAIL end_ack: got valid %b halted %b want 0 1", comm_valid_out, halted_out);
    end
    run_in = 1'b1;
    repeat (20) @(negedge clock);
    run_in = 1'b0;
    tests_run++;
    if (req_count !== 1 || halted_out !== 1'b1) begin
      tests_failed++;
      $display("[TB] FAIL end_absorb: got %0d reqs halted %b want 1 1", req_count, halted_out);
    end
    reset = 1'b1;
    @(negedge clock);
    tests_run++;
    if (halted_out !== 1'b0 || mem_addr_out !== 16'h0000) begin
      tests_failed++;
      $display("[TB] FAIL end_reset: got halted %b pc %h want 0 0000", halted_out, mem_addr_out);
    end
  endtask

  task automatic test_branch_discard();
    bit seen;
    bit saw_valid;
    reset_dut();
    mem_lat = 4;
    mem[16'h0000] = 32'h0000_0BAD;
    mem[16'h0040] = 32'h0000_0C0D;
    exp_ins_q.push_back(32'h0000_0C0D);
    ins_ready_in = 1'b1;
    pulse_run();
    wait_reqs(1, seen);
    @(negedge clock);
    branch_valid_in  = 1'b1;
    branch_target_in = 16'h0040;
    @(negedge clock);
    branch_valid_in  = 1'b0;
    saw_valid = 1'b0;
    seen      = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (ins_valid_out === 1'b1) saw_valid = 1'b1;
      if (addr_q.size() >= 2) begin
        seen = 1'b1;
        break;
      end
      @(negedge clock);
    end
    tests_run++;
    if (saw_valid) begin
      tests_failed++;
      $display("[TB] FAIL branch_discard: got ins_valid 1 want 0");
    end
    tests_run++;
    if (!seen || addr_q[1] !== 16'h0040) begin
      tests_failed++;
      $display("[TB] FAIL branch_target: got %h want 0040", seen ? addr_q[1] : 16'hxxxx);
    end
    wait_ins(seen);
    tests_run++;
    if (!seen || ins_out !== exp_ins_q[0]) begin
      tests_failed++;
      $display("[TB] FAIL branch_word: got %h want %h", ins_out, exp_ins_q[0]);
    end
    void'(exp_ins_q.pop_front());
  endtask

  task automatic test_wrap();
    bit seen;
    reset_dut();
    mem[16'h0000] = 32'h0000_0888;
    mem[16'hFFFF] = 32'h0000_0777;
    exp_ins_q.push_back(32'h0000_0888);
    exp_ins_q.push_back(32'h0000_0777);
    pulse_run();
    wait_ins(seen);
    tests_run++;
    if (!seen || ins_out !== exp_ins_q[0]) begin
      tests_failed++;
      $display("[TB] FAIL wrap_first: got %h want %h", ins_out, exp_ins_q[0]);
    end
    void'(exp_ins_q.pop_front());
    ins_ready_in     = 1'b1;
    branch_valid_in  = 1'b1;
    branch_target_in = 16'hFFFF;
    @(negedge clock);
    branch_valid_in  = 1'b0;
    tests_run++;
    if (ins_valid_out !== 1'b0 || mem_req_out !== 1'b1 || mem_addr_out !== 16'hFFFF) begin
      tests_failed++;
      $display("[TB] FAIL wrap_branch_handshake: got valid %b req %b addr %h want 0 1 ffff",
               ins_valid_out, mem_req_out, mem_addr_out);
    end
    wait_ins(seen);
    tests_run++;
    if (!seen || ins_out !== exp_ins_q[0]) begin
      tests_failed++;
      $display("[TB] FAIL wrap_top_word: got %h want %h", ins_out, exp_ins_q[0]);
    end
    void'(exp_ins_q.pop_front());
    wait_reqs(3, seen);
    tests_run++;
    if (!seen || addr_q[2] !== 16'h0000) begin
      tests_failed++;
      $display("[TB] FAIL wrap_addr: got %h want 0000", seen ? addr_q[2] : 16'hxxxx);
    end
  endtask

  task automatic test_backpressure();
    bit seen;
    int reqs_before;
    reset_dut();
    mem[16'h0000] = 32'hFD00_0000;
    mem[16'h0001] = 32'h0000_0ABC;
    exp_ins_q.push_back(32'h0000_0ABC);
    pulse_run();
    wait_ins(seen);
    reqs_before = req_count;
    tests_run++;
    if (!seen || ins_out !== exp_ins_q[0] || comm_valid_out !== 1'b0 || reqs_before !== 2) begin
      tests_failed++;
      $display("[TB] FAIL nop_skip: got ins %h comm %b reqs %0d want %h 0 2",
               ins_out, comm_valid_out, reqs_before, exp_ins_q[0]);
    end
    for (int i = 0; i < 5; i++) begin
      @(negedge clock);
      tests_run++;
      if (ins_valid_out !== 1'b1 || ins_out !== exp_ins_q[0] || req_count !== reqs_before) begin
        tests_failed++;
        $display("[TB] FAIL stall%0d: got valid %b ins %h reqs %0d want 1 %h %0d",
                 i, ins_valid_out, ins_out, req_count, exp_ins_q[0], reqs_before);
      end
    end
    void'(exp_ins_q.pop_front());
    ins_ready_in = 1'b1;
    @(negedge clock);
    tests_run++;
    if (ins_valid_out !== 1'b0 || mem_addr_out !== 16'h0002) begin
      tests_failed++;
      $display("[TB] FAIL stall_release: got valid %b addr %h want 0 0002", ins_valid_out, mem_addr_out);
    end
  endtask

  initial begin
    test_reset();
    test_basic_issue();
    test_start_comm();
    test_stop();
    test_end();
    test_branch_discard();
    test_wrap();
    test_backpressure();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
